axo32_muldiv_seq: RTL and testbench

Iterative sequencer for the RV32 M-extension: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles with one shared 64-bit shift/add-subtract datapath. It replaces the single-cycle multiplier and divider in the execute stage. The pipeline issues an operation through a valid/ready request port, stalls until the response port fires, and can kill an in-flight operation on a flush.

---
 rtl/axo32_muldiv_seq.sv | 204 ++++++++++++++++++++
 tb/tb_axo32_muldiv_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axo32_muldiv_seq.sv
// axo32_muldiv_seq
//
// This is an iterative RV32 M-extension sequencer. It runs MUL, MULH, MULHSU,
// MULHU, DIV, DIVU, REM and REMU on one shared 64-bit shift/add-subtract
// datapath. A normal operation takes 32 CALC cycles plus one FIXUP cycle.
// Divide-by-zero and signed overflow are resolved when the request is accepted,
// and those operations go straight to DONE.
//
// Ports
//   clk          core clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    operation presented
//   req_ready    sequencer idle and able to accept
//   req_funct3   M-extension funct3 (0 MUL .. 7 REMU)
//   req_lhs      rs1 value
//   req_rhs      rs2 value
//   kill         abort any operation in flight (pipeline flush)
//   resp_valid   result available
//   resp_ready   consumer takes the result
//   resp_data    result, held stable while resp_valid is high

module axo32_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_lhs,
  input  logic [31:0] req_rhs,
  input  logic        kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Two's-complement negation helpers
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = (~v) + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    neg64 = (~v) + 64'd1;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [31:0] resp_data_r;
  logic [2:0]  funct3_r;
  logic        neg_res_r;
  logic [4:0]  count_r;
  // Multiply: {partial product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [63:0] acc_r;
  // Multiplicand magnitude or divisor magnitude
  logic [31:0] op_b_r;

  logic        accept_s;
  logic        lhs_signed_s;
  logic        rhs_signed_s;
  logic        lhs_neg_s;
  logic        rhs_neg_s;
  logic [31:0] lhs_mag_s;
  logic [31:0] rhs_mag_s;
  logic        neg_res_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic        div_ge_s;
  logic [31:0] div_rem_s;
  logic [63:0] acc_next_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] result_s;

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;

  assign accept_s = req_valid && (state_r == ST_IDLE) && !kill;

  // Operand sign handling and special-case detection at accept time
  always_comb begin
    lhs_signed_s  = (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                    (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
    rhs_signed_s  = (req_funct3 == 3'd1) || (req_funct3 == 3'd4) ||
                    (req_funct3 == 3'd6);
    lhs_neg_s     = lhs_signed_s && req_lhs[31];
    rhs_neg_s     = rhs_signed_s && req_rhs[31];
    // 0x80000000 negates to itself, which is already the correct unsigned magnitude
    lhs_mag_s     = lhs_neg_s ? neg32(req_lhs) : req_lhs;
    rhs_mag_s     = rhs_neg_s ? neg32(req_rhs) : req_rhs;
    // The remainder takes the dividend's sign; everything else uses the XOR
    if (req_funct3 == 3'd6) begin
      neg_res_s = lhs_neg_s;
    end else begin
      neg_res_s = lhs_neg_s ^ rhs_neg_s;
    end
    special_s     = 1'b0;
    special_res_s = 32'd0;
    if (req_funct3[2] && (req_rhs == 32'd0)) begin
      special_s     = 1'b1;
      special_res_s = req_funct3[1] ? req_lhs : 32'hFFFF_FFFF;
    end else if (req_funct3[2] && !req_funct3[0] &&
                 (req_lhs == 32'h8000_0000) && (req_rhs == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = req_funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'd0;
    end
  end

  // One shift-add or restoring shift-subtract iteration
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, op_b_r} : 33'd0);
    div_shift_s = {acc_r[63:32], acc_r[31]};
    div_ge_s    = (div_shift_s >= {1'b0, op_b_r});
    // When the trial subtraction succeeds, the difference is below the divisor, so 32 bits hold it
    div_rem_s   = div_ge_s ? (div_shift_s[31:0] - op_b_r) : div_shift_s[31:0];
    if (funct3_r[2]) begin
      acc_next_s = {div_rem_s, acc_r[30:0], div_ge_s};
    end else begin
      acc_next_s = {mul_sum_s, acc_r[31:1]};
    end
  end

  // Sign fix-up and result select for the FIXUP cycle
  always_comb begin
    prod_s = neg_res_r ? neg64(acc_r) : acc_r;
    quo_s  = neg_res_r ? neg32(acc_r[31:0]) : acc_r[31:0];
    rem_s  = neg_res_r ? neg32(acc_r[63:32]) : acc_r[63:32];
    case (funct3_r)
      3'd0:    result_s = prod_s[31:0];
      3'd1:    result_s = prod_s[63:32];
      3'd2:    result_s = prod_s[63:32];
      3'd3:    result_s = prod_s[63:32];
      3'd4:    result_s = quo_s;
      3'd5:    result_s = quo_s;
      3'd6:    result_s = rem_s;
      3'd7:    result_s = rem_s;
      default: result_s = 32'd0;
    endcase
  end

  // Next-state logic; kill overrides every other transition
  always_comb begin
    state_s = state_r;
    if (kill) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_s = req_valid ? (special_s ? ST_DONE : ST_CALC) : ST_IDLE;
        ST_CALC:  state_s = (count_r == 5'd31) ? ST_FIXUP : ST_CALC;
        ST_FIXUP: state_s = ST_DONE;
        ST_DONE:  state_s = resp_ready ? ST_IDLE : ST_DONE;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // State, handshake flags and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      funct3_r     <= 3'd0;
      neg_res_r    <= 1'b0;
      count_r      <= 5'd0;
      acc_r        <= 64'd0;
      op_b_r       <= 32'd0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_DONE);
      if (accept_s) begin
        funct3_r  <= req_funct3;
        neg_res_r <= neg_res_s;
        count_r   <= 5'd0;
        acc_r     <= {32'd0, lhs_mag_s};
        op_b_r    <= rhs_mag_s;
        if (special_s) begin
          resp_data_r <= special_res_s;
        end
      end else if (state_r == ST_CALC) begin
        acc_r   <= acc_next_s;
        count_r <= count_r + 5'd1;
      end else if ((state_r == ST_FIXUP) && !kill) begin
        resp_data_r <= result_s;
      end
    end
  end

endmodule

// File: tb/tb_axo32_muldiv_seq.sv
// Directed testbench for axo32_muldiv_seq. The expected values are worked out by hand.

module tb_axo32_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_lhs;
  logic [31:0] req_rhs;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axo32_muldiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for resp_valid. The latency is the number of edges after the accept edge.
  // The task then checks the data and takes the result.
  task automatic wait_resp(input string tag, input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/data"}, resp_data, exp);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "/idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Presents one request and scrambles the inputs after the accept edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_lhs    = a;
    req_rhs    = b;
    tick();
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_lhs    = $urandom;
    req_rhs    = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    chk({tag, "/rdy"}, {31'd0, req_ready}, 32'd1);
    issue(f3, a, b);
    wait_resp(tag, exp, exp_lat);
  endtask

  initial begin
    logic seen;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'd0;
    req_lhs    = 32'd0;
    req_rhs    = 32'd0;
    kill       = 1'b0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst/req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst/resp_data", resp_data, 32'd0);

    // Normal operations, 33 edges to resp_valid
    run_op("mul",     3'd0, 32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",    3'd1, 32'h8000_0000,   32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulhu2",  3'd3, 32'h0001_0000,   32'h0001_0000, 32'h0000_0001, 33);
    run_op("divu",    3'd5, 32'd100,         32'd7,         32'd14,        33);
    run_op("remu",    3'd7, 32'd100,         32'd7,         32'd2,         33);
    run_op("div",     3'd4, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",     3'd6, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_nn",  3'd4, 32'hFFFF_FFFA,   32'hFFFF_FFFD, 32'd2,         33);
    run_op("rem_pn",  3'd6, 32'd7,           32'hFFFF_FFFE, 32'd1,         33);
    run_op("divu_ov", 3'd5, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         33);

    // Special cases: resp_valid is up in the cycle right after the accept edge
    run_op("div0",    3'd4, 32'd5,           32'd0,         32'hFFFF_FFFF, 0);
    run_op("remu0",   3'd7, 32'd5,           32'd0,         32'd5,         0);
    run_op("divov",   3'd4, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("remov",   3'd6, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         0);

    // Backpressure, followed by a back-to-back request
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 40 && !resp_valid; i++) tick();
    chk("bp/valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp/data", resp_data, 32'hFFFF_FFFD);
      chk("bp/req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp/resp_valid", {31'd0, resp_valid}, 32'd1);
    end
    req_valid  = 1'b1;
    req_funct3 = 3'd6;
    req_lhs    = 32'hFFFF_FFF9;
    req_rhs    = 32'd2;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp/rel_idle", {31'd0, req_ready}, 32'd1);
    chk("bp/rel_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("bp/b2b_accept", {31'd0, req_ready}, 32'd0);
    wait_resp("bp/b2b", 32'hFFFF_FFFF, 33);

    // Kill at CALC count 10
    issue(3'd5, 32'd100, 32'd7);
    repeat (10) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill/idle", {31'd0, req_ready}, 32'd1);
    chk("kill/valid", {31'd0, resp_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    chk("kill/never", {31'd0, seen}, 32'd0);
    run_op("kill/divu", 3'd5, 32'd9, 32'd3, 32'd3, 33);

    // Kill with a request pending in IDLE blocks acceptance
    req_valid  = 1'b1;
    req_funct3 = 3'd0;
    req_lhs    = 32'd3;
    req_rhs    = 32'd3;
    kill       = 1'b1;
    tick();
    kill      = 1'b0;
    req_valid = 1'b0;
    chk("kill/block", {31'd0, req_ready}, 32'd1);

    // Reset in the middle of CALC
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid/req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid/resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstmid/resp_data", resp_data, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    chk("rstmid/never", {31'd0, seen}, 32'd0);
    run_op("rstmid/divu", 3'd5, 32'd9, 32'd3, 32'd3, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
